seq_mul_32bit: RTL and testbench
================================

// Module: seq_mul_32bit
// PURPOSE
// - Iterative 32x32 -> 64-bit shift-add multiplier for the ALU's MUL path.
// - Sits directly upstream of the 32-bit CLA adder and drives it.
//   - Feeds the adder its operands: running high partial product and multiplicand.
//   - Consumes the adder's sum/c_out on every iteration.
// - One adder instance is reused for 32 cycles, trading latency for area.
// - Start/done handshake with the control unit.
//
// PARAMETERS
// - ZERO_SKIP  default 1  1: a zero operand finishes immediately; 0: always runs the full 32 iterations
//
// PORTS
// - clk        in   1   system clock, rising edge
// - rst_n      in   1   asynchronous reset, active-low
// - start      in   1   request; sampled only when the block can accept (IDLE or DONE)
// - op_a       in   32  multiplicand, sampled with an accepted start
// - op_b       in   32  multiplier, sampled with an accepted start
// - is_signed  in   1   present only when MUL_SIGNED_EN is defined
// - busy       out  1   high while in RUN
// - done       out  1   one-cycle pulse: product valid
// - product    out  64  result; held stable until the next accepted start
//
// BEHAVIOUR
// - Reset: async on rst_n low.
//   - state=IDLE; busy=0, done=0, product=0; internal regs and counter cleared.
// - States:
//   - IDLE: waits for start.
//   - RUN: 32 iterations.
//   - DONE: one cycle, done=1.
// - Accept:
//   - start=1 at edge k while in IDLE or DONE is accepted.
//   - Latches mcand=op_a, hi=0, lo=op_b, cnt=0.
//   - Next state is RUN.
//   - In DONE, done still pulses for that cycle; this allows back-to-back operation.
// - start during RUN is ignored: no relatch, no restart.
// - Each RUN edge:
//   - Adder inputs: in1=hi, in2=(lo[0] ? mcand : 0), c_in=0.
//   - {hi,lo} <= {c_out, sum, lo[31:1]}: 65-bit shift right by 1.
//   - cnt <= cnt+1 (6-bit counter).
//   - The edge with cnt==31 moves the state to DONE.
//   - The adder's p/g outputs are unused.
// - Timing: done is high in the cycle after edge k+32, i.e. latency 32 cycles from the sampling edge.
//   - product <= {hi,lo} is registered on the same edge that enters DONE.
// - ZERO_SKIP=1:
//   - If op_a==0 or op_b==0 at an accepted start, go IDLE/DONE -> DONE directly, with product <= 0.
//   - done is then high in the cycle after edge k.
// - DONE -> IDLE unconditionally, unless a new start is accepted.
// - Arithmetic: exact unsigned 64-bit product, never overflows.
//   - Carry out of the adder is kept as the 65th bit before the shift.
// - Reset mid-RUN: immediate abort to IDLE. product=0, no done pulse; partial result is discarded.
//
// CONFIGURATION
// - Macro MUL_SIGNED_EN defined: is_signed port exists.
//   - When is_signed=1 at accept:
//     - Each operand is replaced by its magnitude (two's-complement negate if bit31=1).
//     - sign = op_a[31]^op_b[31] is latched.
//     - On the edge entering DONE, product <= sign ? -{hi,lo} : {hi,lo}, 64-bit negate.
//   - 0x80000000 is treated as magnitude 2^31.
//   - Latency is unchanged; is_signed=0 behaves as unsigned.
// - Macro not defined: no is_signed port, no sign logic; strictly unsigned.
//
// TESTING
// 1. Reset, then op_a=3, op_b=5, start for 1 cycle
//    -> busy=1 for 32 cycles; done one cycle later; product=0x0000000000000000F.
// 2. op_a=op_b=0xFFFFFFFF
//    -> product=0xFFFFFFFE00000001 (exercises c_out into the shift).
// 3. ZERO_SKIP=1, op_a=0, op_b=0x1234
//    -> done in the cycle after the start edge; product=0.
//    ZERO_SKIP=0, same operands -> done after 32 cycles; product=0.
// 4. start with 7*9, then start pulsed again with 2*2 at iteration 10
//    -> second request ignored; product=63.
//    Then start in the DONE cycle with 2*2 -> accepted; product=4 after 32 more cycles.
// 5. rst_n low at iteration 15 of 100*100
//    -> busy=0, done=0, product=0 immediately; no done pulse afterwards.
// 6. op_a=0xFFFFFFFD, op_b=5:
//    - MUL_SIGNED_EN defined, is_signed=1 -> product=0xFFFFFFFFFFFFFFF1.
//    - Macro defined, is_signed=0 -> product=0x00000004FFFFFFF1.
//    - Macro undefined -> product=0x00000004FFFFFFF1.

Source files
------------

// File: rtl/seq_mul_32bit.sv
// Iterative 32x32->64 shift-add multiplier with one reused 32-bit CLA adder; MUL_SIGNED_EN adds is_signed.
// Latency 32 cycles from accepted start to done (1 with a zero operand if ZERO_SKIP); start ignored while busy.

module seq_mul_32bit_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_c;
  logic [7:0]  w_gp;
  logic [7:0]  w_gg;
  logic [8:0]  w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;
  assign w_gc[0] = c_in;

  // Full lookahead inside each 4-bit group, group carries chained between groups.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    assign w_c[B]   = w_gc[gi];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_gp[gi] = &w_p[B+3:B];
    assign w_gg[gi] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_gc[gi+1] = w_gg[gi] | (w_gp[gi] & w_gc[gi]);
  end

  assign sum   = w_p ^ w_c;
  assign c_out = w_gc[8];
endmodule

module seq_mul_32bit #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef MUL_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic [63:0] r_product;

  logic        w_accept;
  logic        w_zero;
  logic        w_last;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_add_b;
  logic [31:0] w_sum;
  logic        w_c_out;
  logic [63:0] w_shift;
  logic [63:0] w_result;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_zero   = (ZERO_SKIP != 0) && ((op_a == 32'd0) || (op_b == 32'd0));
  assign w_last   = (r_state == S_RUN) && (r_cnt == 6'd31);

`ifdef MUL_SIGNED_EN
  logic r_sign;
  // 0x80000000 negates to itself, which read unsigned is the correct magnitude 2^31.
  assign w_mag_a  = (is_signed && op_a[31]) ? (-op_a) : op_a;
  assign w_mag_b  = (is_signed && op_b[31]) ? (-op_b) : op_b;
  assign w_result = r_sign ? (-w_shift) : w_shift;
`else
  assign w_mag_a  = op_a;
  assign w_mag_b  = op_b;
  assign w_result = w_shift;
`endif

  assign w_add_b = r_lo[0] ? r_mcand : 32'd0;

  seq_mul_32bit_cla u_cla (
    .a     (r_hi),
    .b     (w_add_b),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

  // Carry becomes bit 64 of the partial product before the right shift drops bit 0.
  assign w_shift = {w_c_out, w_sum, r_lo[31:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_state_nxt = w_zero ? S_DONE : S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_cnt     <= 6'd0;
      r_product <= 64'd0;
`ifdef MUL_SIGNED_EN
      r_sign    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_mcand <= w_mag_a;
      r_hi    <= 32'd0;
      r_lo    <= w_mag_b;
      r_cnt   <= 6'd0;
`ifdef MUL_SIGNED_EN
      r_sign  <= is_signed & (op_a[31] ^ op_b[31]);
`endif
      if (w_zero) r_product <= 64'd0;
    end else if (r_state == S_RUN) begin
      r_hi  <= w_shift[63:32];
      r_lo  <= w_shift[31:0];
      r_cnt <= r_cnt + 6'd1;
      if (w_last) r_product <= w_result;
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule

// File: tb/tb_seq_mul_32bit.sv
// Randomised scoreboard bench for seq_mul_32bit: u_dut uses ZERO_SKIP=1, u_dut_nz uses ZERO_SKIP=0.
module tb_seq_mul_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
  logic        sg0 = 1'b0, sg1 = 1'b0;
  logic        busy0, done0, busy1, done1;
  logic [63:0] product0, product1;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_32bit #(.ZERO_SKIP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a0), .op_b(op_b0),
`ifdef MUL_SIGNED_EN
    .is_signed(sg0),
`endif
    .busy(busy0), .done(done0), .product(product0)
  );

  seq_mul_32bit #(.ZERO_SKIP(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
`ifdef MUL_SIGNED_EN
    .is_signed(sg1),
`endif
    .busy(busy1), .done(done1), .product(product1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
`ifndef MUL_SIGNED_EN
    s = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) return 64'(sa * sb);
    return {32'd0, a} * {32'd0, b};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) chk("dut_unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut_product", product0, e.prod);
        chk("dut_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("nz_unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("nz_product", product1, e.prod);
        chk("nz_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives a start for one edge and queues the expected result; returns just after the sampling edge.
  task automatic issue(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output bit skipped);
    exp_t e;
    if (!sel) begin start0 = 1'b1; op_a0 = a; op_b0 = b; sg0 = s; end
    else      begin start1 = 1'b1; op_a1 = a; op_b1 = b; sg1 = s; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    op_a0 = $urandom; op_b0 = $urandom; op_a1 = $urandom; op_b1 = $urandom;
    skipped = !sel && (a == 32'd0 || b == 32'd0);
    e.prod = ref_mul(a, b, s);
    e.cyc  = skipped ? cyc : cyc + 32;
    if (!sel) q0.push_back(e); else q1.push_back(e);
    if (!skipped) chk(sel ? "nz_busy_start" : "dut_busy_start", 64'(sel ? busy1 : busy0), 64'd1);
  endtask

  // Full operation; returns inside the DONE cycle so a following call is back-to-back.
  task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    bit sk;
    issue(sel, a, b, s, sk);
    if (!sk) begin
      for (int i = 0; i < 32; i++) begin
        @(posedge clk); #1;
        if (i == 31) chk("busy_low_in_done", 64'(sel ? busy1 : busy0), 64'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit sk;
    #12;
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_done", 64'(done0), 64'd0);
    chk("reset_product", product0, 64'd0);
    chk("reset_product_nz", product1, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    run(0, 32'd3, 32'd5, 1'b0);
    idle(1);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    idle(1);
    run(0, 32'd0, 32'h1234, 1'b0);
    run(0, 32'h1234, 32'd0, 1'b0);
    run(1, 32'd0, 32'h1234, 1'b0);
    idle(2);

    // start mid-run must be ignored, then a start in the DONE cycle is accepted
    issue(0, 32'd7, 32'd9, 1'b0, sk);
    idle(10);
    start0 = 1'b1; op_a0 = 32'd2; op_b0 = 32'd2;
    idle(1);
    start0 = 1'b0;
    chk("busy_after_ignored_start", 64'(busy0), 64'd1);
    idle(21);
    run(0, 32'd2, 32'd2, 1'b0);
    idle(1);

    run(0, 32'hFFFFFFFD, 32'd5, 1'b1);
    run(0, 32'hFFFFFFFD, 32'd5, 1'b0);
    run(0, 32'h80000000, 32'h80000000, 1'b1);
    run(0, 32'h80000000, 32'd1, 1'b1);
    idle(2);

    // reset in the middle of a run aborts without a done pulse
    issue(0, 32'd100, 32'd100, 1'b0, sk);
    idle(15);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_product", product0, 64'd0);
    q0.delete();
    @(negedge clk); rst_n = 1'b1;
    idle(40);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      run(0, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    for (int n = 0; n < 15; n++) begin
      logic [31:0] a;
      a = $urandom;
      run(1, (n % 4 == 0) ? 32'd0 : a, $urandom, 1'($urandom_range(0, 1)));
    end

    idle(4);
    chk("dut_queue_drained", 64'(q0.size()), 64'd0);
    chk("nz_queue_drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
